// File: rtl/cpu_ctrl_pkg.sv
// Shared pipeline-control definitions for the 5-stage core: sequencer state
// encoding, architectural constants and opcodes shared with control_unit.
// Pure definitions; no logic, no latency, no flow control of its own.
package cpu_ctrl_pkg;

  // Multiplier sequencer state
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // x0 is hard-wired to zero, so a load targeting it never creates a hazard
  localparam logic [4:0]  REG_X0    = 5'd0;

  // addi x0, x0, 0 : what a flushed or bubbled stage carries
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // LOAD major opcode, shared with control_unit's decoder
  localparam logic [6:0]  OPC_LOAD  = 7'b000_0011;

endpackage

// File: rtl/mul_latency_counter.sv
// Loadable down-counter timing how long a MUL still occupies EX.
// Latency: loads on the cycle after 'load'; zero flag is combinational from the count.
// Backpressure: none; decrements only when asked and holds at zero.
//
// Ports:
//   clk, rst  : core clock, synchronous active-high reset (count -> 0)
//   load      : preset the count to MUL_LATENCY-2 (cycles of stall after the first)
//   dec       : decrement by one (ignored at zero)
//   zero      : count is zero, i.e. the current cycle is the release cycle
module mul_latency_counter #(
  parameter int MUL_LATENCY = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  // The first occupancy cycle is spent in IDLE and the last is the release
  // cycle, so BUSY only needs to count the MUL_LATENCY-2 stall cycles between.
  localparam logic [3:0] LOAD_VAL = (MUL_LATENCY > 1) ? 4'(MUL_LATENCY - 2) : 4'd0;

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (dec && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/mul_hazard_controller.sv
// Stall/bubble/flush sequencer for the 5-stage core with a multi-cycle MUL in EX.
// Latency: all controls are combinational from state, count and the ID/EX fields.
// Backpressure: holds PC/IF/ID (and ID/EX for MUL) while EX is occupied or a load-use hazard exists.
//
// Ports:
//   clk, rst                     : core clock, synchronous active-high reset
//   id_rs1/id_rs2, id_use_rs1/2  : source registers of the ID instruction and whether they are read
//   ex_rd, ex_mem_read           : destination and load flag of the EX instruction
//   ex_is_mul                    : valid MUL in EX
//   ex_flush_req                 : taken branch/jump resolved in EX
//   pc_write, if_id_write, id_ex_write      : register enables
//   if_id_flush, id_ex_bubble, ex_mem_bubble: NOP injection
//   mul_start, mul_busy          : multiplier start pulse / occupancy beyond first cycle
//   stall_cycles                 : saturating count of cycles with pc_write=0
module mul_hazard_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = 3,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_is_mul,
  input  logic             ex_flush_req,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic             mul_start,
  output logic             mul_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  // A single-cycle multiplier never needs to hold the pipeline
  localparam bit MULTI = (MUL_LATENCY > 1);

  state_t state, state_nxt;
  logic   cnt_zero;
  logic   cnt_load;
  logic   cnt_dec;
  logic   load_use;

  // Load in EX whose destination is read by the instruction in ID
  assign load_use = ex_mem_read && (ex_rd != REG_X0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  assign cnt_load = (state == IDLE) && ex_is_mul && MULTI;
  assign cnt_dec  = (state == BUSY) && !cnt_zero;

  mul_latency_counter #(
    .MUL_LATENCY(MUL_LATENCY)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .dec  (cnt_dec),
    .zero (cnt_zero)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (ex_is_mul && MULTI) state_nxt = BUSY;
      BUSY: if (cnt_zero)           state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // Outputs. A MUL wins over a simultaneous flush (illegal pairing): the
  // flush is dropped. A flush suppresses the load-use check because the
  // ID instruction is being discarded anyway.
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    mul_start     = 1'b0;
    mul_busy      = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (ex_is_mul) begin
            mul_start = 1'b1;
            if (MULTI) begin
              pc_write      = 1'b0;
              if_id_write   = 1'b0;
              id_ex_write   = 1'b0;
              ex_mem_bubble = 1'b1;
            end
          end else if (ex_flush_req) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (load_use) begin
            // Hold ID, let the load move on to MEM, insert one bubble behind it
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        BUSY: begin
          mul_busy = 1'b1;
          // On the release cycle (count zero) everything advances so the
          // product is captured by EX/MEM.
          if (!cnt_zero) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating stall performance counter
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (!pc_write && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: doc/mul_hazard_controller.md
Name: mul_hazard_controller

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core with a multi-cycle multiplier (MULT3) in EX.
- Generates stall, bubble and flush controls for PC, IF/ID, ID/EX and EX/MEM.
- Handles three cases: multiplier occupancy of EX, load-use data hazards, and taken branch/jump flushes.
- Sits beside control_unit in ID/EX and consumes the pipeline-register fields it produces.

Parameters:
- MUL_LATENCY, 3, number of cycles a MUL occupies EX (legal range 1..16).
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- id_rs1  in  5  rs1 index of the instruction in ID
- id_rs2  in  5  rs2 index of the instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  destination index of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_is_mul  in  1  valid MUL instruction in EX
- ex_flush_req  in  1  taken branch or jump resolved in EX
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID register enable
- if_id_flush  out  1  IF/ID loads a NOP
- id_ex_write  out  1  ID/EX register enable
- id_ex_bubble  out  1  ID/EX loads a NOP (control fields zeroed)
- ex_mem_bubble  out  1  EX/MEM loads a NOP
- mul_start  out  1  one-cycle start pulse to the multiplier
- mul_busy  out  1  multiplier occupies EX beyond its first cycle
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- State: IDLE, BUSY; down-counter cnt (4 bits).
- Reset:
  - While rst=1, outputs are forced to pc_write=1, if_id_write=1, id_ex_write=1, all other 1-bit outputs 0.
  - On the next edge: state=IDLE, cnt=0, stall_cycles=0.
  - Reset mid-multiply aborts the operation and returns to IDLE.
- Outputs are combinational from state, cnt and inputs. The default value of every output is its reset value.
- Priority: multiplier > flush > load-use.
- IDLE with ex_is_mul=1 (cycle T):
  - mul_start=1; pc_write=if_id_write=id_ex_write=0; ex_mem_bubble=1.
  - If MUL_LATENCY>1: next state BUSY, cnt=MUL_LATENCY-2.
  - If MUL_LATENCY=1: no stall, no bubble, mul_start=1 only; stay in IDLE.
- BUSY:
  - mul_busy=1; ex_is_mul, ex_flush_req and the load-use check are ignored.
  - cnt>0: same stall and bubble as cycle T; cnt decrements.
  - cnt=0: release cycle. All enables are 1 and ex_mem_bubble=0, so the product passes to EX/MEM. Next state is IDLE.
  - Total EX occupancy is MUL_LATENCY cycles; the front end stalls MUL_LATENCY-1 cycles.
- Back-to-back MULs: the second MUL enters EX the cycle after release, is seen in IDLE and restarts the sequence with no gap cycle.
- Flush (IDLE, ex_flush_req=1, ex_is_mul=0):
  - if_id_flush=1, id_ex_bubble=1, pc_write=1.
  - The load-use check is suppressed.
- Load-use (IDLE, no mul, no flush):
  - Condition: ex_mem_read=1, ex_rd!=0, and ((id_use_rs1 and id_rs1==ex_rd) or (id_use_rs2 and id_rs2==ex_rd)).
  - Response: pc_write=0, if_id_write=0, id_ex_bubble=1, id_ex_write=1.
  - Lasts exactly one cycle, because the load advances to MEM.
- Illegal combination: ex_is_mul and ex_flush_req both 1. The multiplier path wins and the flush is dropped. The bench flags this combination.
- stall_cycles: increments on every non-reset cycle with pc_write=0 and saturates at all-ones.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state encoding: IDLE=1'b0, BUSY=1'b1
  - REG_X0=5'd0
  - NOP instruction constant 32'h00000013
  - LOAD opcode constant shared with control_unit
- One sub-module, mul_latency_counter: loadable down-counter with a zero flag, parameterised by MUL_LATENCY.

Test Plan:
- MUL with MUL_LATENCY=3 at T:
  - mul_start=1 at T only; pc_write=0 at T and T+1; mul_busy=1 at T+1 and T+2.
  - At T+2: all enables 1, ex_mem_bubble=0; stall_cycles=2.
- Load-use: ex_mem_read=1, ex_rd=5, id_use_rs2=1, id_rs2=5 -> one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1. Repeat with ex_rd=0 -> no stall.
- Flush plus hazard: ex_flush_req=1 with a load-use match present -> if_id_flush=1, id_ex_bubble=1, pc_write=1, stall_cycles unchanged.
- Back-to-back MULs (ex_is_mul held 1 for 6 cycles) -> mul_start pulses at T and T+3; stall_cycles=4.
- Reset at T+1 of a MUL -> outputs at reset values during the rst cycle. Next cycle is IDLE with stall_cycles=0, and a new MUL is accepted.
- MUL_LATENCY=1 -> mul_start=1, no stall, mul_busy never asserted; stall_cycles stays 0 over 10 consecutive MULs.
